// File: rtl/acc_read_sequencer.sv
// acc_read_sequencer
// Fetches a contiguous block of words through the arbiter's accelerator port
// and streams them to the datapath. Outstanding plus buffered reads are capped
// at DEPTH, so a stalled consumer can never overflow the response buffer or the
// arbiter's read-tracking FIFO.
module acc_read_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  output logic                out_valid_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                out_last_o,
  input  logic                out_ready_i
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRIDE = DATA_W / 8;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [LEN_W-1:0]   issue_left_reg, issue_left_next;
  logic [LEN_W-1:0]   pop_left_reg, pop_left_next;
  logic [CNT_W-1:0]   outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]   fifo_count_reg, fifo_count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [DATA_W-1:0]  buf_mem [DEPTH];

  logic [CNT_W:0]     credit_sum;
  logic               credit_ok;
  logic               req_valid;
  logic               accept;
  logic               push;
  logic               fifo_valid;
  logic               pop;

  // Handshake qualifiers. Credit counts both in-flight reads and words still
  // sitting in the buffer; a response only moves a read from one to the other,
  // so a raised request cannot lose its credit before it is accepted.
  always_comb begin
    credit_sum = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
    credit_ok  = (credit_sum < CREDIT_MAX);
    req_valid  = (state_reg == ST_RUN) && (issue_left_reg != '0) && credit_ok;
    accept     = req_valid && m_ready_i;
    // Responses with nothing in flight are stale (e.g. issued before a reset).
    push       = m_rvalid_i && (outstanding_reg != '0);
    fifo_valid = (fifo_count_reg != '0);
    pop        = fifo_valid && out_ready_i;
  end

  // Control FSM: next state, address and word counters.
  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    issue_left_next = issue_left_reg;
    pop_left_next   = pop_left_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_next      = ST_RUN;
            addr_next       = base_addr_i;
            issue_left_next = len_i;
            pop_left_next   = len_i;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          addr_next       = addr_reg + ADDR_W'(STRIDE);
          issue_left_next = issue_left_reg - LEN_W'(1);
        end
        if (pop) begin
          pop_left_next = pop_left_reg - LEN_W'(1);
          if (pop_left_reg == LEN_W'(1)) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Buffer bookkeeping: in-flight count, fill level and wrapping pointers.
  always_comb begin
    outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(push);
    fifo_count_next  = fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_next      = push ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;
    rd_ptr_next      = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
  end

  // State and counter registers; reset drops all buffered words by clearing pointers.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      issue_left_reg  <= '0;
      pop_left_reg    <= '0;
      outstanding_reg <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      issue_left_reg  <= issue_left_next;
      pop_left_reg    <= pop_left_next;
      outstanding_reg <= outstanding_next;
      fifo_count_reg  <= fifo_count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // Response storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= m_rdata_i;
    end
  end

  // Outputs. The head word is read straight from storage so a response is
  // visible the cycle after it is written; data is forced to 0 when empty.
  always_comb begin
    busy_o      = (state_reg != ST_IDLE);
    done_o      = (state_reg == ST_DONE);
    m_valid_o   = req_valid;
    m_addr_o    = addr_reg;
    m_wdata_o   = '0;
    m_wstrb_o   = '0;
    out_valid_o = fifo_valid;
    out_data_o  = fifo_valid ? buf_mem[rd_ptr_reg] : '0;
    out_last_o  = fifo_valid && (pop_left_reg == LEN_W'(1));
  end

endmodule

// File: doc/acc_read_sequencer.md
# acc_read_sequencer

Accelerator-side read sequencer that fetches a contiguous block of words from the shared cache and streams them to the accelerator datapath. It sits between the accelerator datapath and the accelerator port of the CPU/accelerator bus arbiter. It issues one read per word and caps outstanding reads so the arbiter's 4-entry read-tracking FIFO never overflows. It buffers responses so the datapath can apply backpressure without losing data.

## Interface
- ADDR_W, 32: byte address width (matches front-end address width).
- DATA_W, 32: data width; address stride is DATA_W/8 bytes.
- LEN_W, 16: word-count width.
- DEPTH, 4: response buffer depth and maximum outstanding-plus-buffered reads (power of 2).

- clk_i  in  1  clock; all logic on rising edge.
- arst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle start pulse; ignored unless idle.
- base_addr_i  in  ADDR_W  first byte address, sampled on accepted start.
- len_i  in  LEN_W  number of words, sampled on accepted start.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- m_valid_o  out  1  read request valid to arbiter.
- m_addr_o  out  ADDR_W  request address.
- m_wdata_o  out  DATA_W  tied 0.
- m_wstrb_o  out  DATA_W/8  tied 0 (read).
- m_ready_i  in  1  request accepted when m_valid_o and m_ready_i are both high.
- m_rdata_i  in  DATA_W  response data.
- m_rvalid_i  in  1  one-cycle response strobe; responses arrive in request order.
- out_valid_o  out  1  stream data valid.
- out_data_o  out  DATA_W  stream data.
- out_last_o  out  1  high with the final word.
- out_ready_i  in  1  consumer ready; a word transfers when out_valid_o and out_ready_i are both high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start_i=1, len_i>0:
  - Load addr=base_addr_i, issue_left=len_i, pop_left=len_i.
  - Go to RUN.
- IDLE, start_i=1, len_i=0: go to DONE; no requests are issued.
- RUN: issue reads while issue_left>0 and credit is available.
  - Credit: outstanding + fifo_count < DEPTH.
  - On accept: addr += DATA_W/8 (wraps mod 2^ADDR_W), issue_left−1, outstanding+1.
- m_valid_o, once high, holds with a stable m_addr_o until accepted.
  - Credit cannot drop before acceptance, since it only decreases by issuing.
- m_rvalid_i with outstanding>0: push m_rdata_i into the FIFO, outstanding−1.
- m_rvalid_i with outstanding=0: ignore (covers stale responses after reset).
- A push and a pop in the same cycle are legal; fifo_count is unchanged.
- Accept and response in the same cycle: outstanding is unchanged.
- Pop on out_valid_o & out_ready_i: pop_left−1.
- out_last_o = (pop_left==1) & out_valid_o.
- RUN → DONE on the pop of the last word (pop_left==1).
- DONE: done_o=1 for one cycle, then IDLE.
- start_i while in RUN or DONE is ignored and latches nothing.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by a count of log2(DEPTH)+1 bits.
- Reset (any state):
  - State returns to IDLE.
  - Counters, FIFO pointers and counts clear to 0; FIFO contents are dropped.

## Timing
- Reset values:
  - 0: busy_o, done_o, m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o, out_valid_o, out_data_o, out_last_o.
- start_i accepted at cycle 0 → busy_o=1 and m_valid_o=1 at cycle 1 (addr=base).
- A request is accepted on an edge where m_ready_i=1. With credit available, the next request is valid in the following cycle, giving one request per cycle.
- Response at cycle t → out_valid_o=1 at t+1 (registered FIFO, no bypass).
- Final pop at cycle t → done_o=1, busy_o=1 at t+1 → busy_o=0 at t+2.
- len=0 start at cycle 0 → done_o=1 at cycle 1, idle at cycle 2.
- Maximum combined outstanding plus buffered reads is DEPTH, so DEPTH=4 never exceeds the arbiter's tracking depth.

## Test plan
- Basic read, DEPTH=4: base=0x100, len=3, m_ready and out_ready tied 1, response 2 cycles after accept.
  - Addresses are 0x100, 0x104, 0x108; data is delivered in order.
  - out_last_o rises with the 3rd word; done_o pulses once.
- Backpressure: len=8, out_ready=0 throughout.
  - Exactly 4 requests are accepted, then m_valid_o stays 0.
  - Raising out_ready_i resumes issue; all 8 words arrive in order, with no loss or duplication.
- Arbiter stall: m_ready_i=0 for 5 cycles with m_valid_o=1.
  - m_addr_o stays stable; the request is accepted on the first m_ready_i=1.
- Edge cases: len=0 gives done_o at cycle 1 with no m_valid_o. base=0xFFFF_FFFC with len=2 gives addresses 0xFFFF_FFFC then 0x0000_0000.
- Simultaneous events and ignored start: a response push and a stream pop in the same cycle leave fifo_count unchanged. start_i asserted during RUN changes nothing.
- Reset mid-run: after 2 requests are accepted, assert arst_i for one cycle.
  - All outputs return to 0 next cycle.
  - Late m_rvalid_i pulses are ignored; out_valid_o stays 0.
  - A new start operates normally.
